// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: pipelined Urdhva Tiryagbhyam multiplier, signed/unsigned.
// One register stage per recursion level; the whole pipe freezes on stall.
module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int D      = WIDTH / 4;
  localparam int LEVELS = $clog2(D);
  localparam int DW     = 2 * WIDTH;

  typedef logic [DW-1:0] dw_t;

  // Kogge-Stone prefix adder; carry out of the top bit is dropped
  function automatic dw_t cla(dw_t x, dw_t y);
    dw_t g;
    dw_t p;
    dw_t pp;
    g  = x & y;
    p  = x ^ y;
    pp = p;
    for (int d = 1; d < DW; d = d * 2) begin
      g  = g | (pp & (g << d));
      pp = pp & (pp << d);
    end
    return p ^ (g << 1);
  endfunction

  // 4x4 vertical-and-crosswise: column sums, then one carry sweep
  function automatic logic [7:0] vedic4(logic [3:0] x, logic [3:0] y);
    logic [2:0] col [7];
    logic [3:0] s;
    logic [2:0] cy;
    logic [7:0] r;
    r  = '0;
    cy = '0;
    for (int k = 0; k < 7; k++) col[k] = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        col[i+j] = col[i+j] + {2'b00, x[i] & y[j]};
    for (int k = 0; k < 7; k++) begin
      s    = {1'b0, col[k]} + {1'b0, cy};
      r[k] = s[0];
      cy   = s[3:1];
    end
    r[7] = cy[0];
    return r;
  endfunction

  // Z-order slot of digit pair (i,j): siblings of one combine are adjacent
  function automatic int morton(int i, int j);
    int r;
    r = 0;
    for (int t = 0; t < 15; t++) begin
      r = r | (((i >> t) & 1) << (2 * t + 1));
      r = r | (((j >> t) & 1) << (2 * t));
    end
    return r;
  endfunction

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k <= LEVELS; k++) begin : stg
    localparam int NB = (D * D) >> (2 * k);
    localparam int PW = 8 << k;
    localparam int TW = NB * PW;

    logic [TW-1:0] c;
    logic [TW-1:0] prod_d;
    logic [TW-1:0] prod_q;
    logic          v_d;
    logic          v_q;
    logic          neg_d;

    if (k == 0) begin : g_in
      logic [WIDTH-1:0] ma;
      logic [WIDTH-1:0] mb;

      // magnitudes, then the full grid of 4x4 digit products
      always_comb begin
        ma = (is_signed & a[WIDTH-1]) ? ~a + 1'b1 : a;
        mb = (is_signed & b[WIDTH-1]) ? ~b + 1'b1 : b;
        c  = '0;
        for (int i = 0; i < D; i++)
          for (int j = 0; j < D; j++)
            c[morton(i, j)*8 +: 8] =
              vedic4(ma[4*i +: 4], mb[4*j +: 4]);
      end

      assign v_d   = in_valid;
      assign neg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else begin : g_cmb
      localparam int CW = PW / 2;
      localparam int M  = PW / 4;

      dw_t ll;
      dw_t lh;
      dw_t hl;
      dw_t hh;

      // LL + (LH+HL)<<M + HH<<2M for every group of four children
      always_comb begin
        c  = '0;
        ll = '0;
        lh = '0;
        hl = '0;
        hh = '0;
        for (int p = 0; p < NB; p++) begin
          ll = dw_t'(stg[k-1].prod_q[(4*p+0)*CW +: CW]);
          lh = dw_t'(stg[k-1].prod_q[(4*p+1)*CW +: CW]);
          hl = dw_t'(stg[k-1].prod_q[(4*p+2)*CW +: CW]);
          hh = dw_t'(stg[k-1].prod_q[(4*p+3)*CW +: CW]);
          c[p*PW +: PW] =
            PW'(cla(cla(ll, cla(lh, hl) << M), hh << (2 * M)));
        end
      end

      assign v_d   = stg[k-1].v_q;
      assign neg_d = stg[k-1].g_mid.neg_q;
    end

    if (k == LEVELS) begin : g_out
      assign prod_d = neg_d ? TW'(cla(~dw_t'(c), dw_t'(1))) : c;
    end else begin : g_mid
      logic neg_q;

      assign prod_d = c;

      // result sign rides along with its sub-products
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          neg_q <= 1'b0;
        end else if (!stall) begin
          neg_q <= neg_d;
        end
      end
    end

    // stage data and valid; all stages hold together on stall
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prod_q <= '0;
        v_q    <= 1'b0;
      end else if (!stall) begin
        prod_q <= prod_d;
        v_q    <= v_d;
      end
    end
  end

  assign out_valid = stg[LEVELS].v_q;
  assign product   = stg[LEVELS].prod_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: directed, reset, backpressure and random checks
// of vedic_mult_pipe at WIDTH 8, plus random sweeps at 4, 16 and 32.
module tb_vedic_mult_pipe;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_s_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int n_tot   = 0;
  int n_bad   = 0;
  int sw_done = 0;
  int n_ov    = 0;

  logic [63:0] mq_p[$];
  int          mq_a[$];

  logic [7:0]  da [7] = '{8'h0E, 8'hFF, 8'h00, 8'h80, 8'hFD, 8'hFF, 8'h7F};
  logic [7:0]  db [7] = '{8'h03, 8'hFF, 8'hA5, 8'h80, 8'h05, 8'hFF, 8'h80};
  bit          ds [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] dp [7] = '{16'h002A, 16'hFE01, 16'h0000, 16'h4000,
                          16'hFFF1, 16'h0001, 16'hC080};

  always #5 clk = ~clk;

  vedic_mult_pipe #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(int w, logic [31:0] x,
                                          logic [31:0] y, bit s);
    longint      sx;
    longint      sy;
    logic [63:0] r;
    logic [63:0] mask;
    if (s) begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
      if (x[w-1]) sx = sx - (longint'(1) << w);
      if (y[w-1]) sy = sy - (longint'(1) << w);
      r = 64'(sx * sy);
    end else begin
      r = {32'b0, x} * {32'b0, y};
    end
    mask = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    return r & mask;
  endfunction

  task automatic step(input bit v, input logic [7:0] x,
                      input logic [7:0] y, input bit s, input bit ordy);
    bit ev;
    bit stl;
    @(negedge clk);
    ev = mq_a.size() > 0 && mq_a[0] == ML;
    chk("ov", 64'(out_valid), 64'(ev));
    if (out_valid) n_ov++;
    if (ev) chk("prod", 64'(product), mq_p[0]);
    in_valid  = v;
    a         = x;
    b         = y;
    is_signed = s;
    out_ready = ordy;
    #1;
    stl = ev && !ordy;
    chk("in_ready", 64'(in_ready), 64'(!stl));
    if (ev && ordy) begin
      void'(mq_p.pop_front());
      void'(mq_a.pop_front());
    end
    if (!stl) foreach (mq_a[i]) mq_a[i]++;
    if (v && !stl) begin
      mq_p.push_back(ref_mul(8, 32'(x), 32'(y), s));
      mq_a.push_back(1);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && mq_a.size() > 0; i++)
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("drain", 64'(mq_a.size()), 64'(0));
  endtask

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
    localparam int L = $clog2(W / 4);

    logic           iv;
    logic           ir;
    logic           sg;
    logic           ov;
    logic           ordy;
    logic [W-1:0]   xa;
    logic [W-1:0]   xb;
    logic [2*W-1:0] pr;
    logic [63:0]    qp[$];
    int             qa[$];

    vedic_mult_pipe #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_s_n),
      .in_valid(iv),
      .in_ready(ir),
      .a(xa),
      .b(xb),
      .is_signed(sg),
      .out_valid(ov),
      .out_ready(ordy),
      .product(pr)
    );

    initial begin : run
      int ops;
      bit ev;
      bit stl;
      ops  = 0;
      iv   = 1'b0;
      ordy = 1'b0;
      sg   = 1'b0;
      xa   = '0;
      xb   = '0;
      wait (rst_s_n === 1'b1);
      for (int cyc = 0; cyc < 20000 && (ops < 1000 || qa.size() > 0);
           cyc++) begin
        @(negedge clk);
        ev = qa.size() > 0 && qa[0] == L + 1;
        chk($sformatf("w%0d_ov", W), 64'(ov), 64'(ev));
        if (ev) chk($sformatf("w%0d_prod", W), 64'(pr), qp[0]);
        iv = ops < 1000 && $urandom_range(0, 3) != 0;
        xa = W'($urandom);
        xb = W'($urandom);
        if ($urandom_range(0, 15) == 0) xa = {1'b1, {(W-1){1'b0}}};
        if ($urandom_range(0, 15) == 0) xb = {1'b1, {(W-1){1'b0}}};
        sg   = $urandom_range(0, 1) == 1;
        ordy = $urandom_range(0, 3) != 0;
        #1;
        stl = ev && !ordy;
        chk($sformatf("w%0d_rdy", W), 64'(ir), 64'(!stl));
        if (ev && ordy) begin
          void'(qp.pop_front());
          void'(qa.pop_front());
        end
        if (!stl) foreach (qa[i]) qa[i]++;
        if (iv && !stl) begin
          qp.push_back(ref_mul(W, 32'(xa), 32'(xb), sg));
          qa.push_back(1);
          ops++;
        end
      end
      chk($sformatf("w%0d_ops", W), 64'(ops), 64'(1000));
      chk($sformatf("w%0d_drain", W), 64'(qa.size()), 64'(0));
      sw_done++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rst_s_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_prod", 64'(product), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n   = 1'b1;
    rst_s_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 64'(in_ready), 64'(1));

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      a         = da[i];
      b         = db[i];
      is_signed = ds[i];
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("dir%0d_lat1", i), 64'(out_valid), 64'(0));
      @(negedge clk);
      chk($sformatf("dir%0d_lat2", i), 64'(out_valid), 64'(1));
      chk($sformatf("dir%0d_prod", i), 64'(product), 64'(dp[i]));
    end

    @(negedge clk);
    in_valid  = 1'b1;
    a         = 8'h0E;
    b         = 8'h03;
    is_signed = 1'b0;
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    @(posedge clk);
    #1;
    chk("pre_rst_ov", 64'(out_valid), 64'(1));
    chk("pre_rst_prod", 64'(product), 64'(16'h002A));
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(out_valid), 64'(0));
    chk("mid_rst_prod", 64'(product), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(in_ready), 64'(1));
    repeat (4) begin
      @(negedge clk);
      chk("stale", 64'(out_valid), 64'(0));
    end

    n_ov = 0;
    for (int i = 0; i < 16; i++)
      step(1'b1, 8'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1, 1'b1);
    drain();
    chk("b2b_cnt", 64'(n_ov), 64'(16));

    step(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    repeat (5)
      step(1'b1, 8'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1, 1'b0);
    drain();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    drain();

    wait (sw_done == 3);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
